// File: rtl/vote_argmax_accumulator.sv
// Vote accumulator with sequential argmax readout.
// Spike packets vote for class (packet_in mod NUM_CLASSES) while accumulating.
// After FRAMES_PER_DECISION frames the per-class counters are scanned, one
// class per cycle. The winner (lowest index on ties) is presented on a
// valid/ready result port, and accumulation restarts.
module vote_argmax_accumulator #(
  parameter int NUM_CLASSES         = 9,
  parameter int PACKET_WIDTH        = 8,
  parameter int COUNT_WIDTH         = 16,
  parameter int FRAMES_PER_DECISION = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PACKET_WIDTH-1:0]        packet_in,
  input  logic                           packet_valid,
  input  logic                           frame_done,
  input  logic                           clr,
  output logic [$clog2(NUM_CLASSES)-1:0] result_class,
  output logic [COUNT_WIDTH-1:0]         result_votes,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           busy,
  output logic [15:0]                    dropped_cnt,
  output logic                           overrun
);

  localparam int IW = $clog2(NUM_CLASSES);
  // The modulo is evaluated in a width that can always hold NUM_CLASSES (<= 64).
  localparam int MW = (PACKET_WIDTH > 7) ? PACKET_WIDTH : 7;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);
  localparam logic [7:0]    FPD_LAST = 8'(FRAMES_PER_DECISION - 1);

  typedef enum logic {ACCUM, SCAN} state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] counters [NUM_CLASSES];
  logic [7:0]             frame_cnt;
  logic [IW-1:0]          scan_idx;
  logic [IW-1:0]          best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;

  logic [MW-1:0]          pkt_ext;
  logic [MW-1:0]          pkt_class;
  logic [NUM_CLASSES-1:0] hit;
  logic [COUNT_WIDTH-1:0] cur_cnt;
  logic                   cand_take;
  logic [IW-1:0]          cand_idx;
  logic [COUNT_WIDTH-1:0] cand_cnt;
  logic                   accum_clr;
  logic                   decision_due;
  logic                   scan_last;

  // Class decode of the incoming packet (one-hot over classes).
  always_comb begin
    pkt_ext   = MW'(packet_in);
    pkt_class = pkt_ext % MW'(NUM_CLASSES);
    hit       = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      hit[i] = (pkt_class == MW'(i));
    end
  end

  // Scan datapath: read the counter at scan_idx and pick the running best.
  // Index 0 always seeds the best so an all-zero frame yields class 0.
  always_comb begin
    cur_cnt = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == IW'(i)) cur_cnt = counters[i];
    end
    cand_take = (scan_idx == '0) || (cur_cnt > best_cnt);
    cand_idx  = cand_take ? scan_idx : best_idx;
    cand_cnt  = cand_take ? cur_cnt  : best_cnt;
  end

  // Control qualifiers shared by the FSM and the datapath registers.
  always_comb begin
    accum_clr    = (state == ACCUM) && clr;
    decision_due = (state == ACCUM) && !clr && frame_done && (frame_cnt == FPD_LAST);
    scan_last    = (state == SCAN) && (scan_idx == LAST_IDX);
  end

  // Next-state logic and status output.
  always_comb begin
    state_nxt = state;
    busy      = (state == SCAN);
    case (state)
      ACCUM:   if (decision_due) state_nxt = SCAN;
      SCAN:    if (scan_last)    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Per-class saturating vote counters; cleared by clr or at the end of a scan.
  always_ff @(posedge clk) begin
    if (rst || accum_clr || scan_last) begin
      counters <= '{default: '0};
    end else if ((state == ACCUM) && packet_valid) begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
        if (hit[i] && (counters[i] != '1)) counters[i] <= counters[i] + 1'b1;
      end
    end
  end

  // Frame counter: wraps to zero on the frame that completes a decision.
  always_ff @(posedge clk) begin
    if (rst || accum_clr) begin
      frame_cnt <= '0;
    end else if ((state == ACCUM) && frame_done) begin
      if (frame_cnt == FPD_LAST) frame_cnt <= '0;
      else                       frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Scan index and running best, parked at zero while accumulating.
  always_ff @(posedge clk) begin
    if (rst || (state == ACCUM)) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else begin
      scan_idx <= scan_idx + 1'b1;
      best_idx <= cand_idx;
      best_cnt <= cand_cnt;
    end
  end

  // Result register with valid/ready hold and sticky overrun.
  // A load on the accepting cycle keeps valid high without flagging overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_class <= '0;
      result_votes <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (scan_last) begin
      result_class <= cand_idx;
      result_votes <= cand_cnt;
      result_valid <= 1'b1;
      if (result_valid && !result_ready) overrun <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  // Saturating count of packets that arrive while scanning.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_cnt <= '0;
    end else if ((state == SCAN) && packet_valid && (dropped_cnt != '1)) begin
      dropped_cnt <= dropped_cnt + 16'd1;
    end
  end

endmodule
